// File: rtl/cmp_int_serial.sv
// cmp_int_serial: bit-serial integer comparator, MSB first, one bit pair per cycle.
// Handshaked request (in_valid/in_ready) and result (out_valid/out_ready).
// Optional macro CMP_INT_SERIAL_EARLY_EXIT_EN: finish on the first differing bit
// instead of always walking all WIDTH bits.
module cmp_int_serial #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    localparam logic [1:0] OP_GT = 2'd0;
    localparam logic [1:0] OP_LT = 2'd1;
    localparam logic [1:0] OP_EQ = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [1:0]        op_q;
    logic              gt_q, lt_q;
    logic [IW-1:0]     idx_q;

    logic a_bit, b_bit, diff, decided, eq, last_bit;

    assign a_bit    = a_q[idx_q];
    assign b_bit    = b_q[idx_q];
    assign diff     = a_bit ^ b_bit;
    assign decided  = gt_q | lt_q;
    assign eq       = !gt_q && !lt_q;
    assign last_bit = (idx_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        Y         = 1'b0;
        out_gt    = 1'b0;
        out_lt    = 1'b0;
        out_eq    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef CMP_INT_SERIAL_EARLY_EXIT_EN
                if (last_bit || (diff && !decided)) begin
                    state_d = DONE;
                end
`else
                if (last_bit) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                out_gt    = gt_q;
                out_lt    = lt_q;
                out_eq    = eq;
                case (op_q)
                    OP_GT:   Y = gt_q;
                    OP_LT:   Y = lt_q;
                    OP_EQ:   Y = eq;
                    default: Y = gt_q | eq;
                endcase
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch and serial decision datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        gt_q  <= 1'b0;
                        lt_q  <= 1'b0;
                        idx_q <= MSB_IDX;
                    end
                end
                RUN: begin
                    // First difference decides; the sign bit has inverted weight
                    if (diff && !decided) begin
                        if (SIGNED && (idx_q == MSB_IDX)) begin
                            lt_q <= a_bit;
                            gt_q <= b_bit;
                        end else begin
                            gt_q <= a_bit;
                            lt_q <= !a_bit;
                        end
                    end
                    if (!last_bit) begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_int_serial.sv
// tb_cmp_int_serial: checks a signed and an unsigned comparator instance driven
// in parallel against an arithmetic reference model.
// Honors CMP_INT_SERIAL_EARLY_EXIT_EN for the expected latency.
module tb_cmp_int_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a_in, b_in;
    logic [1:0]  op_in;
    logic        out_ready;

    logic in_ready_s, out_valid_s, y_s, gt_s, lt_s, eq_s;
    logic in_ready_u, out_valid_u, y_u, gt_u, lt_u, eq_u;

    int checks;
    int passed;

    cmp_int_serial #(.WIDTH(16), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .A(a_in), .B(b_in), .op(op_in), .out_valid(out_valid_s),
        .out_ready(out_ready), .Y(y_s), .out_gt(gt_s), .out_lt(lt_s), .out_eq(eq_s)
    );

    cmp_int_serial #(.WIDTH(16), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .A(a_in), .B(b_in), .op(op_in), .out_valid(out_valid_u),
        .out_ready(out_ready), .Y(y_u), .out_gt(gt_u), .out_lt(lt_u), .out_eq(eq_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {Y, gt, lt, eq} from plain arithmetic comparison
    function automatic logic [3:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] o, input bit sg);
        logic gt, lt, eq, y;
        if (sg) gt = ($signed(a) > $signed(b));
        else    gt = (a > b);
        eq = (a == b);
        lt = !gt && !eq;
        case (o)
            2'd0:    y = gt;
            2'd1:    y = lt;
            2'd2:    y = eq;
            default: y = gt | eq;
        endcase
        return {y, gt, lt, eq};
    endfunction

    // Cycles from accept edge to out_valid
    function automatic int latency(input logic [15:0] a, input logic [15:0] b);
`ifdef CMP_INT_SERIAL_EARLY_EXIT_EN
        for (int i = 15; i >= 0; i--) begin
            if (a[i] != b[i]) return 16 - i;
        end
        return 16;
`else
        if (a == b) return 16;
        return 16;
`endif
    endfunction

    task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] o, input int stall);
        logic [3:0] es, eu, held;
        int el, cyc;
        es = model(a, b, o, 1'b1);
        eu = model(a, b, o, 1'b0);
        el = latency(a, b);
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready_s), 32'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        op_in = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        op_in = 2'($urandom);
        chk("busy_in_ready", 32'(in_ready_s), 32'd0);
        cyc = 0;
        while (!out_valid_s && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(el));
        chk("valid_u", 32'(out_valid_u), 32'd1);
        chk("flags_s", 32'({y_s, gt_s, lt_s, eq_s}), 32'(es));
        chk("flags_u", 32'({y_u, gt_u, lt_u, eq_u}), 32'(eu));
        held = {y_s, gt_s, lt_s, eq_s};
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid_s), 32'd1);
            chk("stall_flags", 32'({y_s, gt_s, lt_s, eq_s}), 32'(held));
            chk("stall_in_ready", 32'(in_ready_s), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_in_ready", 32'({in_ready_s, in_ready_u}), 32'h3);
        chk("post_out", 32'({out_valid_s, y_s, gt_s, lt_s, eq_s, out_valid_u, y_u}), 32'd0);
    endtask

    initial begin
        int seen;
        logic [15:0] r;
        checks = 0;
        passed = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        op_in = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'({in_ready_s, in_ready_u}), 32'h3);
        chk("rst_out_s", 32'({out_valid_s, y_s, gt_s, lt_s, eq_s}), 32'd0);
        chk("rst_out_u", 32'({out_valid_u, y_u, gt_u, lt_u, eq_u}), 32'd0);

        // Sign-bit boundary: signed says less, unsigned says greater
        run_cmp(16'h8000, 16'h7FFF, 2'd0, 0);
        // Equal operands under EQ and GE
        run_cmp(16'h1234, 16'h1234, 2'd2, 0);
        run_cmp(16'h1234, 16'h1234, 2'd3, 0);
        // Difference at bit 14
        run_cmp(16'h4000, 16'h0000, 2'd0, 0);
        // Difference only at bit 0, and a DONE stall with ignored requests
        run_cmp(16'hFFFE, 16'hFFFF, 2'd1, 5);
        run_cmp(16'h7FFF, 16'hFFFF, 2'd3, 0);

        for (int n = 0; n < 16; n++) begin
            r = 16'($urandom);
            case (n % 4)
                0:       run_cmp(r, r, 2'($urandom), 0);
                1:       run_cmp(r, r ^ 16'(1 << (n % 16)), 2'($urandom), 0);
                default: run_cmp(r, 16'($urandom), 2'($urandom), (n % 3));
            endcase
        end

        // Reset during RUN discards the compare
        r = 16'($urandom);
        @(negedge clk);
        in_valid = 1'b1;
        a_in = r;
        b_in = r;
        op_in = 2'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'({in_ready_s, in_ready_u}), 32'h3);
        chk("midrst_valid", 32'({out_valid_s, out_valid_u}), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid_s || out_valid_u) seen++;
        end
        chk("midrst_no_pulse", 32'(seen), 32'd0);
        run_cmp(16'h8001, 16'h0001, 2'd1, 0);
        run_cmp(16'($urandom), 16'($urandom), 2'($urandom), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cmp_int_serial.md
CMP_INT_SERIAL -- requirements
Module: cmp_int_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement compare and 0 = unsigned compare.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port A  input  WIDTH  first operand, sampled on accept.
REQ-008 SHALL have port B  input  WIDTH  second operand, sampled on accept.
REQ-009 SHALL have port op  input  2  compare mode, sampled on accept: 0=GT, 1=LT, 2=EQ, 3=GE.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Y  output  1  predicate result for the latched op.
REQ-013 SHALL have port out_gt  output  1  A>B flag.
REQ-014 SHALL have port out_lt  output  1  A<B flag.
REQ-015 SHALL have port out_eq  output  1  A==B flag.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-017 SHALL hold in_ready high only in IDLE; accept occurs on an edge where in_valid&&in_ready, which latches A, B and op, clears gt/lt, loads bit index WIDTH-1, and moves to RUN.
REQ-018 SHALL consume one bit pair per RUN cycle, MSB first, decrementing the bit index each edge.
REQ-019 SHALL treat unequal bits at index WIDTH-1 when SIGNED=1 as inverted: A bit 1 sets lt, B bit 1 sets gt.
REQ-020 SHALL treat unequal bits at any other index, or at any index when SIGNED=0, as: A bit 1 sets gt, otherwise lt.
REQ-021 SHALL, on the first difference, set gt or lt once; later bits SHALL NOT change the decision.
REQ-022 SHALL transition RUN->DONE on the edge that processes bit 0, so out_valid rises WIDTH cycles after the accept edge.
REQ-023 SHALL, in DONE, hold out_valid=1 and Y, out_gt, out_lt and out_eq stable until out_valid&&out_ready, then return to IDLE.
REQ-024 SHALL assert in_ready only from the cycle after result handoff, with no same-cycle pass-through.
REQ-025 SHALL compute out_eq as !gt&&!lt, and Y as GT:gt, LT:lt, EQ:eq, GE:gt|eq.
REQ-026 SHALL drive out_valid, Y and all flags to 0 outside DONE.
REQ-027 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-028 SHALL NOT let operand changes after accept affect the result.

Reset
REQ-029 SHALL, when rst is high at a clock edge, set the FSM to IDLE and clear gt, lt, the bit index and the latched operands, with reset taking priority over every other event.
REQ-030 SHALL drive in_ready=1, out_valid=0, Y=0, out_gt=0, out_lt=0 and out_eq=0 in the cycle after reset.
REQ-031 SHALL, when reset is asserted in RUN or DONE, discard the in-flight compare with no out_valid pulse.

Configuration
REQ-032 SHALL, with CMP_INT_SERIAL_EARLY_EXIT_EN defined, transition RUN->DONE on the edge that detects the first differing bit, giving latency = WIDTH-1-k+1 cycles for first difference at bit k, and WIDTH cycles for equal operands.
REQ-033 SHALL, without CMP_INT_SERIAL_EARLY_EXIT_EN, use a fixed latency of WIDTH cycles for all operands, producing identical Y and flag values in both builds.

Verification
REQ-034 SHALL cover: WIDTH=16, SIGNED=1, A=0x8000, B=0x7FFF, op=GT -> Y=0, out_lt=1, out_valid 16 cycles after accept.
REQ-035 SHALL cover: SIGNED=0, same operands, op=GT -> Y=1, out_gt=1.
REQ-036 SHALL cover: A=B=0x1234, op=EQ, then op=GE -> Y=1, out_eq=1, latency 16 in both builds.
REQ-037 SHALL cover: macro defined, A=0x4000, B=0x0000, op=GT -> Y=1, out_valid 2 cycles after accept; macro undefined -> 16 cycles.
REQ-038 SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid and Y stable, in_ready=0, and a new in_valid is ignored.
REQ-039 SHALL cover: rst asserted at RUN cycle 7 -> next cycle IDLE, in_ready=1, no out_valid, and the next compare is correct.
